// File: rtl/ext_com_pkg.sv
// Definitions shared by the external-link responder and the on-board data transmitter.
package ext_com_pkg;

  localparam int unsigned UART_WIDTH     = 8;
  localparam int unsigned UART_BAUD_RATE = 230400;
  localparam logic [7:0]  UART_ACK       = 8'b11001100;

  typedef enum logic [2:0] {
    StIdle,
    StRxStart,
    StRxData,
    StRxStop,
    StWaitHigh,
    StTxStart,
    StTxData,
    StTxStop
  } ext_resp_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: half_tick marks mid start bit, full_tick marks a bit boundary.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic clk,
  input  logic rstN,
  input  logic clear,
  input  logic enable,
  output logic half_tick,
  output logic full_tick
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Ticks fire in the last cycle of the interval so the FSM acts on the following edge.
  assign half_tick = enable && (cnt_q == CntW'(CLKS_PER_BIT / 2 - 1));
  assign full_tick = enable && (cnt_q == CntW'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/ext_com_responder.sv
// Far-end UART responder: receives one frame, pulses data_valid, optionally answers with ACK.
module ext_com_responder #(
  parameter int unsigned UART_WIDTH     = ext_com_pkg::UART_WIDTH,
  parameter int unsigned CLK_FREQ       = 50_000_000,
  parameter int unsigned UART_BAUD_RATE = ext_com_pkg::UART_BAUD_RATE
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  rx,
  input  logic                  ack_en,
  output logic                  tx,
  output logic [UART_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  frame_error,
  output logic                  busy
);
  import ext_com_pkg::*;

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / UART_BAUD_RATE;
  localparam int unsigned BitCntW      = (UART_WIDTH > 1) ? $clog2(UART_WIDTH) : 1;

  ext_resp_state_t       state_q, state_d;
  logic                  rx_meta_q, rx_s_q;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [UART_WIDTH-1:0] shift_q, shift_d;
  logic [UART_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  tx_q, tx_d;
  logic                  timer_clear, timer_enable;
  logic                  half_tick, full_tick;
  logic                  last_bit;

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .rstN      (rstN),
    .clear     (timer_clear),
    .enable    (timer_enable),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  assign last_bit     = (bit_cnt_q == BitCntW'(UART_WIDTH - 1));
  assign timer_enable = (state_q != StIdle);
  assign timer_clear  = (state_q == StIdle) || (state_d != state_q) || full_tick;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (!rx_s_q) state_d = StRxStart;
      end
      StRxStart: begin
        // A start bit that is high again at its midpoint was only a glitch.
        if (half_tick) state_d = rx_s_q ? StIdle : StRxData;
      end
      StRxData: begin
        if (full_tick) begin
          shift_d = {rx_s_q, shift_q[UART_WIDTH-1:1]};
          if (last_bit) begin
            bit_cnt_d = '0;
            state_d   = StRxStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StRxStop: begin
        if (full_tick) begin
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = ack_en ? StTxStart : StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        if (rx_s_q) state_d = StIdle;
      end
      StTxStart: begin
        if (full_tick) state_d = StTxData;
      end
      StTxData: begin
        if (full_tick) begin
          if (last_bit) begin
            bit_cnt_d = '0;
            state_d   = StTxStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StTxStop: begin
        if (full_tick) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // tx is registered from the current state, so the start bit lands the cycle after data_valid.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      StTxStart: tx_d = 1'b0;
      StTxData:  tx_d = UART_ACK[bit_cnt_q];
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      tx_q      <= tx_d;
    end
  end

  assign tx          = tx_q;
  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign frame_error = ferr_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_ext_com_responder.sv
// Self-checking bench for ext_com_responder: directed spec scenarios plus random frames.
module tb_ext_com_responder;

  localparam int unsigned BIT = 217;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       rx = 1'b1;
  logic       ack_en = 1'b0;
  logic       tx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;
  int unsigned fe_cnt = 0;
  int unsigned both_cnt = 0;
  int unsigned tx_low_cnt = 0;

  logic [7:0]  dv_q[$];
  int unsigned dv_cyc[$];
  logic [7:0]  ack_q[$];
  logic        ack_stop_q[$];
  int unsigned tx_start_q[$];

  logic [7:0] ack_ref = 8'b11001100;
  logic [7:0] model_last = 8'h00;

  ext_com_responder dut (
    .clk         (clk),
    .rstN        (rstN),
    .rx          (rx),
    .ack_en      (ack_en),
    .tx          (tx),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse and line monitor, sampled 2 time units after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (data_valid === 1'b1) begin
        dv_q.push_back(data_out);
        dv_cyc.push_back(cyc);
      end
      if (frame_error === 1'b1) fe_cnt++;
      if (data_valid === 1'b1 && frame_error === 1'b1) both_cnt++;
      if (tx !== 1'b1) tx_low_cnt++;
    end
  end

  // Reference UART receiver decoding tx at bit midpoints.
  initial begin
    logic [7:0]  b;
    int unsigned t0;
    forever begin
      @(posedge clk);
      #2;
      if (rstN === 1'b1 && tx === 1'b0) begin
        t0 = cyc;
        repeat (BIT / 2) @(posedge clk);
        #2;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(posedge clk);
          #2;
          b[i] = tx;
        end
        repeat (BIT) @(posedge clk);
        #2;
        ack_q.push_back(b);
        ack_stop_q.push_back(tx);
        tx_start_q.push_back(t0);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    wait_cycles(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(BIT);
    end
    rx = stop_bit;
    wait_cycles(BIT);
  endtask

  task automatic wait_ack(input int unsigned n_before);
    int unsigned k = 0;
    while (ack_q.size() <= n_before && k < 4000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("ack_seen", 32'(ack_q.size() > n_before), 32'd1);
  endtask

  // Good frame with ACK enabled; returns the cycle of its data_valid pulse.
  task automatic acked_frame(input logic [7:0] b, input string tag, output int unsigned d);
    int unsigned n_dv, n_ack, fs;
    int          lat, lat_exp;
    ack_en = 1'b1;
    n_dv   = dv_q.size();
    n_ack  = ack_q.size();
    fs     = cyc;
    d      = 0;
    send_frame(b, 1'b1);
    model_last = b;
    check({tag, "_dv_count"}, 32'(dv_q.size()), 32'(n_dv + 1));
    if (dv_q.size() > n_dv) begin
      d       = dv_cyc[n_dv];
      lat     = int'(d) - int'(fs);
      lat_exp = (lat >= 2062 && lat <= 2066) ? lat : 2064;
      check({tag, "_latency"}, 32'(lat), 32'(lat_exp));
      check({tag, "_dv_data"}, 32'(dv_q[n_dv]), 32'(b));
    end
    check({tag, "_data_out"}, 32'(data_out), 32'(model_last));
    wait_ack(n_ack);
    if (ack_q.size() > n_ack) begin
      check({tag, "_ack_byte"}, 32'(ack_q[n_ack]), 32'(ack_ref));
      check({tag, "_ack_stop"}, 32'(ack_stop_q[n_ack]), 32'd1);
      check({tag, "_ack_start_cycle"}, tx_start_q[n_ack], d + 1);
    end
    wait_until(d + 10 * BIT - 1);
    check({tag, "_busy_last_cycle"}, 32'(busy), 32'd1);
    wait_until(d + 10 * BIT);
    check({tag, "_busy_dropped"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int unsigned d, fs, n_dv, n_fe, n_ack, n_low;
    logic [7:0]  b;
    logic        en, bad;

    // Reset values
    rstN = 1'b0;
    rx = 1'b1;
    ack_en = 1'b1;
    wait_cycles(3);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    rstN = 1'b1;
    wait_cycles(1000);
    check("idle_tx", 32'(tx), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_no_dv", 32'(dv_q.size()), 32'd0);
    check("idle_no_fe", 32'(fe_cnt), 32'd0);
    check("idle_tx_never_low", 32'(tx_low_cnt), 32'd0);

    // First ACKed frame
    acked_frame(8'b00101010, "f2a", d);

    // Framing error, rx held low afterwards
    n_dv = dv_q.size();
    n_fe = fe_cnt;
    n_low = tx_low_cnt;
    ack_en = 1'b1;
    send_frame(8'hA5, 1'b0);
    wait_cycles(500);
    check("ferr_pulse", 32'(fe_cnt), 32'(n_fe + 1));
    check("ferr_no_dv", 32'(dv_q.size()), 32'(n_dv));
    check("ferr_data_held", 32'(data_out), 32'(model_last));
    check("ferr_wait_high_busy", 32'(busy), 32'd1);
    check("ferr_tx_idle", 32'(tx_low_cnt), 32'(n_low));
    rx = 1'b1;
    wait_cycles(10);
    check("ferr_back_idle", 32'(busy), 32'd0);

    // 50-cycle glitch
    n_dv = dv_q.size();
    n_fe = fe_cnt;
    fs = cyc;
    rx = 1'b0;
    wait_cycles(50);
    rx = 1'b1;
    wait_until(fs + 60);
    check("glitch_in_start", 32'(busy), 32'd1);
    wait_until(fs + 115);
    check("glitch_back_idle", 32'(busy), 32'd0);
    check("glitch_no_dv", 32'(dv_q.size()), 32'(n_dv));
    check("glitch_no_fe", 32'(fe_cnt), 32'(n_fe));

    // Back-to-back frames without ACK
    ack_en = 1'b0;
    n_dv = dv_q.size();
    n_low = tx_low_cnt;
    send_frame(8'hFF, 1'b1);
    send_frame(8'h00, 1'b1);
    wait_cycles(20);
    model_last = 8'h00;
    check("b2b_dv_count", 32'(dv_q.size()), 32'(n_dv + 2));
    if (dv_q.size() >= n_dv + 2) begin
      check("b2b_first", 32'(dv_q[n_dv]), 32'hFF);
      check("b2b_second", 32'(dv_q[n_dv+1]), 32'h00);
    end
    check("b2b_tx_high", 32'(tx_low_cnt), 32'(n_low));
    check("b2b_data_out", 32'(data_out), 32'(model_last));

    // Random frames against the behavioural model
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      en = 1'($urandom_range(0, 1));
      bad = ($urandom_range(0, 3) == 0);
      ack_en = en;
      n_dv = dv_q.size();
      n_fe = fe_cnt;
      n_ack = ack_q.size();
      send_frame(b, !bad);
      rx = 1'b1;
      if (!bad) model_last = b;
      if (!bad && en) begin
        wait_ack(n_ack);
        wait_cycles(300);
      end else begin
        wait_cycles(20);
      end
      check("rnd_dv_count", 32'(dv_q.size()), 32'(n_dv + (bad ? 0 : 1)));
      check("rnd_fe_count", 32'(fe_cnt), 32'(n_fe + (bad ? 1 : 0)));
      check("rnd_ack_count", 32'(ack_q.size()), 32'(n_ack + ((!bad && en) ? 1 : 0)));
      check("rnd_data_out", 32'(data_out), 32'(model_last));
      check("rnd_idle", 32'(busy), 32'd0);
      if (ack_q.size() > n_ack) check("rnd_ack_byte", 32'(ack_q[n_ack]), 32'(ack_ref));
    end

    // Reset halfway through the 4th ACK data bit
    ack_en = 1'b1;
    n_dv = dv_q.size();
    send_frame(8'h3C, 1'b1);
    d = (dv_q.size() > n_dv) ? dv_cyc[n_dv] : cyc;
    wait_until(d + 1 + BIT * 4 + BIT / 2);
    check("rst4_tx_before", 32'(tx), 32'(ack_ref[3]));
    rstN = 1'b0;
    #1;
    check("rst4_tx_async", 32'(tx), 32'd1);
    check("rst4_busy", 32'(busy), 32'd0);
    check("rst4_data_out", 32'(data_out), 32'd0);
    model_last = 8'h00;
    wait_cycles(3);
    rstN = 1'b1;
    wait_cycles(2500);
    ack_q.delete();
    ack_stop_q.delete();
    tx_start_q.delete();
    acked_frame(8'h5A, "f5a", d);

    // Reset during a low ACK bit: tx must rise without waiting for a clock edge
    ack_en = 1'b1;
    n_dv = dv_q.size();
    send_frame(8'hC3, 1'b1);
    d = (dv_q.size() > n_dv) ? dv_cyc[n_dv] : cyc;
    wait_until(d + 1 + BIT * 5 + BIT / 2);
    check("rst5_tx_before", 32'(tx), 32'(ack_ref[4]));
    rstN = 1'b0;
    #1;
    check("rst5_tx_async", 32'(tx), 32'd1);
    wait_cycles(3);
    rstN = 1'b1;
    wait_cycles(10);

    check("dv_fe_exclusive", 32'(both_cnt), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ext_com_responder.md
# ext_com_responder

Far-end responder for the external UART link: receives one 8-bit data frame on `rx`, presents it as a one-cycle `data_valid` pulse, then answers on `tx` with the fixed ACK byte 8'b11001100. It is the peer that the on-board data transmitter (send-data / wait-ACK / retransmit) talks to. It is synthesised onto the external FPGA and also instantiated in benches as a cycle-accurate link partner. Half-duplex per transaction: `rx` is ignored while the ACK is being sent.

## Interface
- `UART_WIDTH`, 8, data bits per frame
- `CLK_FREQ`, 50_000_000, clock frequency in Hz
- `UART_BAUD_RATE`, 230400, link baud rate
- `CLKS_PER_BIT`, CLK_FREQ/UART_BAUD_RATE (=217), derived localparam
- `clk` in 1: system clock
- `rstN` in 1: reset; one clock; reset is asynchronous and active-low
- `rx` in 1: serial input, idle high
- `ack_en` in 1: 1 = send ACK after a good frame; 0 = receive only, suppress ACK
- `tx` out 1: serial output, idle high
- `data_out` out UART_WIDTH: last correctly received byte, held until the next good frame
- `data_valid` out 1: one-cycle pulse when `data_out` updates
- `frame_error` out 1: one-cycle pulse when the stop bit samples low
- `busy` out 1: high in every state except IDLE

## Operation
- `rx` passes through a 2-flop synchroniser before use; all references to `rx` below mean `rx_s`.
- States are IDLE, RX_START, RX_DATA, RX_STOP, WAIT_HIGH, TX_START, TX_DATA, TX_STOP.
- IDLE: `tx`=1. When `rx_s`=0, clear the bit timer and go to RX_START.
- RX_START: wait CLKS_PER_BIT/2 (108) cycles, then sample. If 0, go to RX_DATA. If 1, treat as a glitch and return to IDLE with no pulse.
- RX_DATA: every CLKS_PER_BIT cycles, shift the sample into the data register, LSB first. After UART_WIDTH samples, go to RX_STOP.
- RX_STOP: after CLKS_PER_BIT cycles, sample the stop bit.
  - If 1: load `data_out`, pulse `data_valid`. Go to TX_START if `ack_en`=1, otherwise go to IDLE.
  - If 0: pulse `frame_error`, leave `data_out` unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s`=1, then go to IDLE. No ACK is sent.
- TX_START: drive `tx`=0 for CLKS_PER_BIT cycles.
- TX_DATA: drive the ACK bits LSB first, each for CLKS_PER_BIT cycles. Wire order is 0,0,1,1,0,0,1,1.
- TX_STOP: drive `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- `ack_en` is sampled only in the RX_STOP exit cycle.
- Any `rx` activity during the TX states is ignored. A frame whose start bit falls inside the ACK is lost; this is required behaviour because the sender only transmits after it sees the ACK.
- Bit timer width is $clog2(CLKS_PER_BIT). The timer clears on every state transition and on every bit boundary.

## Timing
- Reset values: `tx`=1, `data_out`=0, `data_valid`=0, `frame_error`=0, `busy`=0, state = IDLE.
- Reset asserted mid-frame or mid-ACK forces the reset values immediately. `tx` returns high asynchronously, and any partial frame is discarded.
- Latency from the `rx` falling edge to `data_valid` is 2 + 108 + 9×217 + 1 = 2064 cycles. Benches allow ±2 cycles.
- The `tx` start bit begins on the cycle after `data_valid`.
- The full ACK occupies 10×217 = 2170 cycles. `busy` drops on the cycle after the stop bit ends.
- `data_valid` and `frame_error` are never high in the same cycle.
- Back-to-back frames with `ack_en`=0: a new start bit is accepted on the first cycle `rx_s`=0 in IDLE. IDLE is entered one cycle after the RX_STOP sample, so the minimum spacing is 1 stop bit.

## Structure
- Package `ext_com_pkg` holds:
  - `UART_ACK` = 8'b11001100
  - the `ext_resp_state_t` enum
  - the shared `UART_WIDTH` / `UART_BAUD_RATE` defaults, which top-level and the data transmitter also use.
- One sub-module, `uart_bit_timer`: a counter with `clear`/`enable` inputs and `half_tick` / `full_tick` outputs, parameterised by CLKS_PER_BIT. It is shared with the on-board transmitter.
- Expected size: 180–260 lines of RTL including the sub-module.

## Test plan
- Reset, then idle 1000 cycles → `tx`=1, `busy`=0, no pulses.
- Send 8'b00101010 with `ack_en`=1 → `data_valid` at 2064±2 cycles with `data_out`=8'h2A. The bench UART receiver then decodes 8'b11001100 on `tx`, and `busy` falls 2170 cycles later.
- Send 8'hA5 with the stop bit forced low → `frame_error` pulse, `data_out` stays 8'h2A, `tx` stays 1. With `rx` held low 500 extra cycles, the block stays in WAIT_HIGH until `rx` rises.
- Drive a 50-cycle low glitch on `rx` → no `data_valid`, no `frame_error`, back in IDLE at cycle ≈111.
- Send 8'hFF then 8'h00 back-to-back with `ack_en`=0 → two `data_valid` pulses with `data_out` 8'hFF then 8'h00, and `tx` constantly 1.
- Assert `rstN`=0 halfway through the ACK's 4th bit → `tx`=1 in the same cycle. After release, a new frame 8'h5A is received and ACKed normally.
